// File: rtl/psum_accumulator.sv
// psum_accumulator
//   Accumulates signed 20-bit partial sums from the 16-input adder stage into
//   a saturating ACC_W-bit accumulator, one tile at a time. The beat flagged
//   with in_last closes the tile: the total is arithmetically shifted right by
//   SHIFT, clamped to 16 bits and held until the consumer accepts it.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
//   valid && ready. Producers keep data stable while valid && !ready.
//   in_ready depends only on state; out_valid depends only on state.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   psum_in    signed partial sum (20 bits)
//   in_valid   psum_in carries a beat
//   in_last    final beat of the tile (qualified by in_valid)
//   in_ready   block accepts a beat this cycle (ACC state)
//   acc_out    signed shifted + saturated tile result
//   out_valid  acc_out / beat_cnt / sat_flag valid (HOLD state)
//   out_ready  consumer accepts the result
//   beat_cnt   beats in the tile, saturating at 255
//   sat_flag   accumulator or output clamp occurred during the tile
module psum_accumulator #(
    parameter int SHIFT = 4,
    parameter int ACC_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [19:0] psum_in,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic signed [15:0] acc_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         beat_cnt,
    output logic               sat_flag
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-32768);

    state_t state;
    state_t state_next;

    // Running tile state (cleared when a tile closes)
    logic signed [ACC_W-1:0] acc;
    logic [7:0]              cnt;
    logic                    sat_run;

    logic                    accept;
    logic                    out_fire;
    logic signed [ACC_W:0]   sum_wide;
    logic                    acc_ovf;
    logic signed [ACC_W-1:0] acc_next;
    logic [7:0]              cnt_next;
    logic signed [ACC_W-1:0] shifted;
    logic                    out_clamp;
    logic signed [15:0]      result;

    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // One extra bit of headroom: overflow shows as the top two bits differing.
    assign sum_wide = {acc[ACC_W-1], acc}
                    + {{(ACC_W-19){psum_in[19]}}, psum_in};
    assign acc_ovf  = sum_wide[ACC_W] != sum_wide[ACC_W-1];

    always_comb begin
        acc_next = sum_wide[ACC_W-1:0];
        if (acc_ovf) begin
            acc_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    assign cnt_next = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

    // >>> on a signed operand gives floor rounding toward -inf.
    assign shifted = acc_next >>> SHIFT;

    always_comb begin
        out_clamp = 1'b0;
        result    = shifted[15:0];
        if (shifted > OUT_MAX) begin
            out_clamp = 1'b1;
            result    = 16'sh7FFF;
        end else if (shifted < OUT_MIN) begin
            out_clamp = 1'b1;
            result    = 16'sh8000;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ACC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_ACC:  if (accept && in_last) state_next = ST_HOLD;
            ST_HOLD: if (out_fire)          state_next = ST_ACC;
            default:                        state_next = ST_ACC;
        endcase
    end

    // Output decode: handshake outputs come from state alone.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_ACC:  in_ready  = 1'b1;
            ST_HOLD: out_valid = 1'b1;
            default: in_ready  = 1'b1;
        endcase
    end

    // Datapath: accumulate in ACC; on the last beat, publish the result into
    // the output registers and restart the running state for the next tile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            sat_run  <= 1'b0;
            acc_out  <= '0;
            beat_cnt <= '0;
            sat_flag <= 1'b0;
        end else begin
            if (accept) begin
                if (in_last) begin
                    acc      <= '0;
                    cnt      <= '0;
                    sat_run  <= 1'b0;
                    acc_out  <= result;
                    beat_cnt <= cnt_next;
                    sat_flag <= sat_run | acc_ovf | out_clamp;
                end else begin
                    acc     <= acc_next;
                    cnt     <= cnt_next;
                    sat_run <= sat_run | acc_ovf;
                end
            end
            if (out_fire) begin
                acc_out  <= '0;
                beat_cnt <= '0;
                sat_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator (SHIFT=4, ACC_W=32).
module tb_psum_accumulator;

    logic               clk;
    logic               rst;
    logic signed [19:0] psum_in;
    logic               in_valid;
    logic               in_last;
    logic               in_ready;
    logic signed [15:0] acc_out;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         beat_cnt;
    logic               sat_flag;

    int n_checks;
    int n_fail;

    psum_accumulator #(
        .SHIFT (4),
        .ACC_W (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .psum_in   (psum_in),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .acc_out   (acc_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .beat_cnt  (beat_cnt),
        .sat_flag  (sat_flag)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_last  = 1'b0;
        psum_in  = '0;
    endtask

    task automatic beat(input logic signed [19:0] v, input logic last);
        in_valid = 1'b1;
        psum_in  = v;
        in_last  = last;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        out_ready = 1'b0;
        rst = 1'b0;
        // Put the block in HOLD with a nonzero result, then reset mid-cycle.
        step();
        beat(20'sd160, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid);
        end
        n_checks++;
        if (acc_out !== 16'sd0) begin
            n_fail++; $display("FAIL reset_acc_out got %0d want 0", acc_out);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready);
        end
        #1;
        rst = 1'b0;
        step();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_ready got in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_single_beat();
        out_ready = 1'b1;
        beat(20'sd100, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || acc_out !== 16'sd6 || beat_cnt !== 8'd1 || sat_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL single_beat got v=%0b out=%0d cnt=%0d sat=%0b want 1/6/1/0", out_valid, acc_out, beat_cnt, sat_flag);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_beat_release got v=%0b rdy=%0b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_negative_floor();
        out_ready = 1'b0;
        beat(-20'sd17, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || acc_out !== -16'sd2 || beat_cnt !== 8'd1 || sat_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL neg_floor got v=%0b out=%0d cnt=%0d sat=%0b want 1/-2/1/0", out_valid, acc_out, beat_cnt, sat_flag);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_output_saturation();
        // 4 x 524287 = 2097148; >>4 = 131071 -> clamp to 32767
        for (int i = 0; i < 4; i++) beat(20'sd524287, i == 3);
        n_checks++;
        if (acc_out !== 16'sd32767 || beat_cnt !== 8'd4 || sat_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL out_sat_pos got out=%0d cnt=%0d sat=%0b want 32767/4/1", acc_out, beat_cnt, sat_flag);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (sat_flag !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_clear got sat=%0b v=%0b want 0/0", sat_flag, out_valid);
        end
        // 4 x -524288 = -2097152; >>4 = -131072 -> clamp to -32768
        for (int i = 0; i < 4; i++) beat(-20'sd524288, i == 3);
        n_checks++;
        if (acc_out !== -16'sd32768 || beat_cnt !== 8'd4 || sat_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL out_sat_neg got out=%0d cnt=%0d sat=%0b want -32768/4/1", acc_out, beat_cnt, sat_flag);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        beat(20'sd16, 1'b0);
        beat(20'sd32, 1'b1);
        in_valid = 1'b1;
        psum_in  = 20'sd48;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || acc_out !== 16'sd3 || beat_cnt !== 8'd2) begin
                n_fail++;
                $display("FAIL hold_cycle%0d got rdy=%0b v=%0b out=%0d cnt=%0d want 0/1/3/2", i, in_ready, out_valid, acc_out, beat_cnt);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        // Handshake edge: pending beat must not have been taken.
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL no_bypass got v=%0b rdy=%0b want 0/1", out_valid, in_ready);
        end
        out_ready = 1'b0;
        step();
        idle_inputs();
        n_checks++;
        if (out_valid !== 1'b1 || acc_out !== 16'sd3 || beat_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL fresh_tile got v=%0b out=%0d cnt=%0d want 1/3/1", out_valid, acc_out, beat_cnt);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_mid_tile_reset();
        beat(20'sd1000, 1'b0);
        beat(20'sd2000, 1'b0);
        #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
        beat(20'sd160, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || acc_out !== 16'sd10 || beat_cnt !== 8'd1 || sat_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset got v=%0b out=%0d cnt=%0d sat=%0b want 1/10/1/0", out_valid, acc_out, beat_cnt, sat_flag);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_beat_cnt_saturation();
        // 300 beats of 1: sum 300 >> 4 = 18, count pinned at 255, no clamp.
        for (int i = 0; i < 300; i++) beat(20'sd1, i == 299);
        n_checks++;
        if (acc_out !== 16'sd18 || beat_cnt !== 8'd255 || sat_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL cnt_sat got out=%0d cnt=%0d sat=%0b want 18/255/0", acc_out, beat_cnt, sat_flag);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_acc_saturation();
        // 4096 x 524287 = 2147479552; one more beat overflows 32-bit signed.
        // Clamped acc stays positive -> 32767; a wrapped acc would give -32768.
        for (int i = 0; i < 4097; i++) beat(20'sd524287, i == 4096);
        n_checks++;
        if (acc_out !== 16'sd32767 || beat_cnt !== 8'd255 || sat_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL acc_sat got out=%0d cnt=%0d sat=%0b want 32767/255/1", acc_out, beat_cnt, sat_flag);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        // Consumer always ready: tiles 64, then -32+-32, then 0.
        out_ready = 1'b1;
        beat(20'sd64, 1'b1);
        n_checks++;
        if (acc_out !== 16'sd4 || beat_cnt !== 8'd1) begin
            n_fail++; $display("FAIL b2b_t0 got out=%0d cnt=%0d want 4/1", acc_out, beat_cnt);
        end
        step();
        beat(-20'sd32, 1'b0);
        beat(-20'sd32, 1'b1);
        n_checks++;
        if (acc_out !== -16'sd4 || beat_cnt !== 8'd2 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_t1 got out=%0d cnt=%0d v=%0b want -4/2/1", acc_out, beat_cnt, out_valid);
        end
        step();
        beat(20'sd0, 1'b1);
        n_checks++;
        if (acc_out !== 16'sd0 || beat_cnt !== 8'd1 || sat_flag !== 1'b0) begin
            n_fail++; $display("FAIL b2b_t2 got out=%0d cnt=%0d sat=%0b want 0/1/0", acc_out, beat_cnt, sat_flag);
        end
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        out_ready = 1'b0;
        idle_inputs();
        #12;
        test_reset();
        test_single_beat();
        test_negative_floor();
        test_output_saturation();
        test_backpressure();
        test_mid_tile_reset();
        test_beat_cnt_saturation();
        test_acc_saturation();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
